// File: rtl/bf_pkg.sv
// Shared types and constants for the path tracer: controller states, abort codes
// and the default "no predecessor" marker.
package bf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRead,
        StWait,
        StEmit,
        StFin,
        StErr
    } state_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrBadArg  = 2'd1;
    localparam logic [1:0] ErrUnreach = 2'd2;
    localparam logic [1:0] ErrCycle   = 2'd3;

    localparam logic [7:0] NoPred = 8'hFF;

endpackage

// File: rtl/path_stack.sv
// LIFO holding the traced path; the destination is pushed first so pops yield the
// path source-first.
module path_stack #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       top,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned SpW = $clog2(DEPTH) + 1;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SpW-1:0]   sp_q, sp_d;
    logic [AW-1:0]    wr_idx, top_idx;
    logic             do_push, do_pop;

    assign full    = (sp_q == SpW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign depth   = sp_q;
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign wr_idx  = AW'(sp_q);
    assign top_idx = AW'(sp_q - SpW'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (do_push) begin
            sp_d = sp_q + SpW'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SpW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: nothing is visible above the stack pointer.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/path_tracer.sv
// Walks a predecessor table back from the destination to the source, then streams
// the recovered path source-first over a valid/ready interface.
module path_tracer
    import bf_pkg::*;
#(
    parameter int unsigned MAX_VERTS = 32,
    parameter logic [7:0]  NO_PRED   = NoPred
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] source_num,
    input  logic [7:0] destination,
    input  logic [7:0] vertice_num,
    output logic       pred_rd_en,
    output logic [7:0] pred_rd_addr,
    input  logic [7:0] pred_rd_data,
    output logic       path_valid,
    input  logic       path_ready,
    output logic [7:0] path_vertex,
    output logic       path_last,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);
    localparam int unsigned SpW = $clog2(MAX_VERTS) + 1;

    state_e     state_q, state_d;
    logic [7:0] src_q, src_d, dst_q, dst_d, n_q, n_d;
    logic [7:0] cur_q, cur_d, hops_q, hops_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] pred_rd_addr_q, pred_rd_addr_d;
    logic       pred_rd_en_q, pred_rd_en_d;
    logic       busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic           st_clear, st_push, st_pop, st_full, st_empty;
    logic [7:0]     st_push_data, st_top;
    logic [SpW-1:0] st_depth;
    logic           bad_arg, bad_pred, hop_limit;

    path_stack #(
        .DEPTH (MAX_VERTS),
        .WIDTH (8)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .clear     (st_clear),
        .push      (st_push),
        .pop       (st_pop),
        .push_data (st_push_data),
        .top       (st_top),
        .depth     (st_depth),
        .full      (st_full),
        .empty     (st_empty)
    );

    assign bad_arg = (src_q == 8'd0) || (dst_q == 8'd0) || (n_q == 8'd0) ||
                     (src_q > n_q) || (dst_q > n_q) || (32'(n_q) > MAX_VERTS);
    assign bad_pred = (pred_rd_data == NO_PRED) || (pred_rd_data == 8'd0) ||
                      (pred_rd_data > n_q);
    // Depth here is before pushing p, so +1 is the depth once p is on the stack.
    assign hop_limit = (hops_q + 8'd1 >= n_q) || (32'(st_depth) + 32'd1 >= MAX_VERTS);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        n_d          = n_q;
        cur_d        = cur_q;
        hops_d       = hops_q;
        err_code_d   = err_code_q;
        st_clear     = 1'b0;
        st_push      = 1'b0;
        st_pop       = 1'b0;
        st_push_data = 8'd0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    src_d      = source_num;
                    dst_d      = destination;
                    n_d        = vertice_num;
                    hops_d     = 8'd0;
                    err_code_d = ErrNone;
                    st_clear   = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (bad_arg) begin
                    err_code_d = ErrBadArg;
                    state_d    = StErr;
                end else begin
                    st_push      = 1'b1;
                    st_push_data = dst_q;
                    if (dst_q == src_q) begin
                        state_d = StEmit;
                    end else begin
                        cur_d   = dst_q;
                        state_d = StRead;
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                if (bad_pred) begin
                    err_code_d = ErrUnreach;
                    state_d    = StErr;
                end else begin
                    st_push      = !st_full;
                    st_push_data = pred_rd_data;
                    hops_d       = hops_q + 8'd1;
                    if (pred_rd_data == src_q) begin
                        state_d = StEmit;
                    end else if (hop_limit) begin
                        err_code_d = ErrCycle;
                        state_d    = StErr;
                    end else begin
                        cur_d   = pred_rd_data;
                        state_d = StRead;
                    end
                end
            end
            StEmit: begin
                if (path_ready && !st_empty) begin
                    st_pop = 1'b1;
                    if (st_depth == SpW'(1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        pred_rd_en_d   = (state_d == StRead);
        pred_rd_addr_d = pred_rd_en_d ? cur_d : 8'd0;
        busy_d         = (state_d != StIdle);
        done_d         = (state_d == StFin);
        error_d        = (state_d == StErr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            src_q          <= 8'd0;
            dst_q          <= 8'd0;
            n_q            <= 8'd0;
            cur_q          <= 8'd0;
            hops_q         <= 8'd0;
            err_code_q     <= ErrNone;
            pred_rd_en_q   <= 1'b0;
            pred_rd_addr_q <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            n_q            <= n_d;
            cur_q          <= cur_d;
            hops_q         <= hops_d;
            err_code_q     <= err_code_d;
            pred_rd_en_q   <= pred_rd_en_d;
            pred_rd_addr_q <= pred_rd_addr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    // Path outputs decode only flops, so they hold steady while the consumer stalls.
    assign path_valid   = (state_q == StEmit);
    assign path_vertex  = path_valid ? st_top : 8'd0;
    assign path_last    = path_valid && (st_depth == SpW'(1));
    assign pred_rd_en   = pred_rd_en_q;
    assign pred_rd_addr = pred_rd_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: directed scenarios plus randomized traces, all checked
// against a queue-based model of the predecessor walk.
module tb_path_tracer;
    localparam int MaxV = 32;
    localparam int Limit = 400;

    logic       clock, reset, start, path_ready;
    logic [7:0] source_num, destination, vertice_num, pred_rd_data;
    logic       pred_rd_en, path_valid, path_last, busy, done, error;
    logic [7:0] pred_rd_addr, path_vertex;
    logic [1:0] err_code;

    path_tracer #(
        .MAX_VERTS (MaxV),
        .NO_PRED   (8'hFF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .source_num   (source_num),
        .destination  (destination),
        .vertice_num  (vertice_num),
        .pred_rd_en   (pred_rd_en),
        .pred_rd_addr (pred_rd_addr),
        .pred_rd_data (pred_rd_data),
        .path_valid   (path_valid),
        .path_ready   (path_ready),
        .path_vertex  (path_vertex),
        .path_last    (path_last),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pred_mem [256];
    int  exp_q[$];
    int  exp_addr[$];
    int  got_q[$];
    bit  exp_err;
    int  exp_code;
    bit  active = 0;
    int  rd_cnt, done_cnt, err_cnt;
    bit  prev_valid, prev_ready, prev_last;
    int  prev_vertex;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Predecessor memory: data appears one cycle after the strobe, junk otherwise.
    always @(posedge clock) begin
        pred_rd_data <= pred_rd_en ? pred_mem[pred_rd_addr] : 8'($urandom);
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: walk predecessors from dst with a queue, rules taken directly from
    // the behaviour description rather than from any state machine.
    task automatic model(input int s, input int d, input int n);
        int cur, p, hops;
        exp_q.delete();
        exp_addr.delete();
        exp_err  = 0;
        exp_code = 0;
        if (s == 0 || d == 0 || n == 0 || s > n || d > n || n > MaxV) begin
            exp_err  = 1;
            exp_code = 1;
            return;
        end
        exp_q.push_front(d);
        if (d == s) return;
        cur  = d;
        hops = 0;
        forever begin
            exp_addr.push_back(cur);
            p = int'(pred_mem[cur]);
            if (p == 255 || p == 0 || p > n) begin
                exp_err = 1; exp_code = 2; exp_q.delete(); return;
            end
            exp_q.push_front(p);
            hops++;
            if (p == s) return;
            if (hops >= n || exp_q.size() >= MaxV) begin
                exp_err = 1; exp_code = 3; exp_q.delete(); return;
            end
            cur = p;
        end
    endtask

    // Per-cycle compare against the model's expected stream and read addresses.
    initial begin
        prev_valid = 0;
        forever begin
            @(negedge clock);
            if (!reset && active) begin
                if (path_valid) begin
                    chk(exp_q.size() > 0, "valid_unexpected", int'(path_vertex), -1);
                    if (exp_q.size() > 0) begin
                        chk(int'(path_vertex) == exp_q[0], "vertex", int'(path_vertex), exp_q[0]);
                        chk(path_last == (exp_q.size() == 1), "last", int'(path_last),
                            int'(exp_q.size() == 1));
                    end
                    if (path_ready) begin
                        got_q.push_back(int'(path_vertex));
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end
                if (prev_valid && !prev_ready) begin
                    chk(path_valid && int'(path_vertex) == prev_vertex && path_last == prev_last,
                        "stall_hold", int'(path_vertex), prev_vertex);
                end
                if (pred_rd_en) begin
                    rd_cnt++;
                    chk(exp_addr.size() > 0 && int'(pred_rd_addr) == exp_addr[0], "rd_addr",
                        int'(pred_rd_addr), exp_addr.size() > 0 ? exp_addr[0] : -1);
                    if (exp_addr.size() > 0) void'(exp_addr.pop_front());
                end
                if (done) done_cnt++;
                if (error) err_cnt++;
            end
            prev_valid  = path_valid && !reset && active;
            prev_ready  = path_ready;
            prev_vertex = int'(path_vertex);
            prev_last   = path_last;
        end
    end

    task automatic check_quiet(input string tag);
        chk(busy == 0, {tag, "_busy"}, int'(busy), 0);
        chk(done == 0 && error == 0, {tag, "_pulses"}, int'({done, error}), 0);
        chk(err_code == 0, {tag, "_err_code"}, int'(err_code), 0);
        chk(pred_rd_en == 0 && pred_rd_addr == 0, {tag, "_rd"}, int'(pred_rd_addr), 0);
        chk(path_valid == 0 && path_vertex == 0 && path_last == 0, {tag, "_path"},
            int'(path_vertex), 0);
    endtask

    // Called at posedge+1 with the DUT idle; start is presented immediately.
    task automatic run_trace(input int s, input int d, input int n, input int mode);
        int cyc;
        model(s, d, n);
        got_q.delete();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0;
        source_num = 8'(s); destination = 8'(d); vertice_num = 8'(n);
        start = 1;
        active = 1;
        @(posedge clock); #1;
        start = 0;
        chk(busy == 1, "busy_after_start", int'(busy), 1);
        chk(err_code == 0, "err_code_cleared", int'(err_code), 0);
        cyc = 0;
        while (done_cnt == 0 && err_cnt == 0 && cyc < Limit) begin
            path_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            if (mode == 2) begin
                start       = ($urandom_range(0, 3) == 0);
                source_num  = 8'($urandom);
                destination = 8'($urandom);
                vertice_num = 8'($urandom);
            end
            @(posedge clock); #1;
            cyc++;
        end
        start = 0;
        chk(cyc < Limit, "timeout", cyc, Limit);
        @(posedge clock); #1;
        chk(done_cnt == (exp_err ? 0 : 1), "done_pulses", done_cnt, exp_err ? 0 : 1);
        chk(err_cnt == (exp_err ? 1 : 0), "error_pulses", err_cnt, exp_err ? 1 : 0);
        chk(int'(err_code) == exp_code, "err_code", int'(err_code), exp_code);
        chk(exp_q.size() == 0, "path_left", exp_q.size(), 0);
        chk(exp_addr.size() == 0, "reads_left", exp_addr.size(), 0);
        chk(busy == 0 && path_valid == 0, "idle_after", int'(busy), 0);
        active = 0;
        path_ready = 0;
    endtask

    task automatic clear_preds();
        for (int i = 0; i < 256; i++) pred_mem[i] = 8'hFF;
    endtask

    initial begin
        int n, s, d, cyc, r;
        reset = 1; start = 0; path_ready = 0;
        source_num = 0; destination = 0; vertice_num = 0;
        clear_preds();
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset_state");
        reset = 0;

        // 4 -> 3 -> 2 -> 1, ready held high.
        pred_mem[4] = 3; pred_mem[3] = 2; pred_mem[2] = 1;
        model(1, 4, 4);
        chk(exp_q.size() == 4 && exp_q[0] == 1 && exp_q[3] == 4, "model_pin_chain",
            exp_q.size(), 4);
        run_trace(1, 4, 4, 0);
        chk(got_q.size() == 4 && got_q[0] == 1 && got_q[1] == 2 && got_q[2] == 3 &&
            got_q[3] == 4, "chain_order", got_q.size(), 4);
        chk(rd_cnt == 3, "chain_reads", rd_cnt, 3);

        // Same chain with ready toggling.
        run_trace(1, 4, 4, 1);
        chk(got_q.size() == 4 && got_q[0] == 1 && got_q[3] == 4, "toggle_order",
            got_q.size(), 4);

        // src == dst.
        run_trace(2, 2, 4, 0);
        chk(got_q.size() == 1 && got_q[0] == 2 && rd_cnt == 0, "self_path", rd_cnt, 0);

        // Unreachable.
        clear_preds();
        model(1, 3, 4);
        chk(exp_err && exp_code == 2, "model_pin_unreach", exp_code, 2);
        run_trace(1, 3, 4, 0);
        chk(err_code == 2 && rd_cnt == 1 && got_q.size() == 0, "unreach", int'(err_code), 2);

        // 3 -> 2 -> 3 cycle.
        pred_mem[3] = 2; pred_mem[2] = 3;
        model(1, 3, 3);
        chk(exp_err && exp_code == 3, "model_pin_cycle", exp_code, 3);
        run_trace(1, 3, 3, 0);
        chk(err_code == 3 && rd_cnt == 3, "cycle", int'(err_code), 3);

        // Longest legal chain fills the stack exactly; N above the limit is rejected.
        clear_preds();
        for (int v = 2; v <= MaxV; v++) pred_mem[v] = 8'(v - 1);
        run_trace(1, MaxV, MaxV, 2);
        chk(got_q.size() == MaxV && rd_cnt == MaxV - 1, "full_chain", got_q.size(), MaxV);
        run_trace(1, MaxV, MaxV + 1, 0);
        chk(err_code == 1, "n_too_big", int'(err_code), 1);

        // Reset in WAIT abandons the trace; the next cycle's start is accepted.
        clear_preds();
        pred_mem[4] = 3; pred_mem[3] = 2; pred_mem[2] = 1;
        source_num = 1; destination = 4; vertice_num = 4; start = 1;
        @(posedge clock); #1;
        start = 0;
        cyc = 0;
        while (!pred_rd_en && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk(pred_rd_en == 1, "reach_read", int'(pred_rd_en), 1);
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        check_quiet("after_reset");
        run_trace(1, 5, 4, 0);
        chk(err_code == 1, "bad_arg_after_reset", int'(err_code), 1);

        // Randomized traces.
        for (int t = 0; t < 60; t++) begin
            clear_preds();
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(1, MaxV);
            s = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(0, n + 1);
            d = $urandom_range(0, n + 1);
            if ($urandom_range(0, 9) == 0) d = s;
            for (int v = 1; v <= 40; v++) begin
                r = $urandom_range(0, 19);
                if (r == 0) pred_mem[v] = 8'hFF;
                else if (r == 1) pred_mem[v] = 8'd0;
                else if (r == 2) pred_mem[v] = 8'(n + 1);
                else if (r < 8) pred_mem[v] = 8'($urandom_range(1, n > 0 ? n : 1));
                else pred_mem[v] = (v > 1) ? 8'($urandom_range(1, v - 1)) : 8'(s);
            end
            run_trace(s, d, n, t % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
